prg_tile_sched: RTL and testbench

- Parametrised successor to the primary-ray pixel stepper.
- Walks a frame in screen tiles, not a single raster, and emits SPP sample slots per pixel.
- Issue is credit-gated against the downstream ray pipeline plus FIFO, and a drain/done phase marks frame completion.
- Sits between the frame-start control and the PRG direction pipeline; its (x, y, s) stream feeds the per-pixel direction and jitter maths.

---
 rtl/prg_tile_sched.sv | 148 ++++++++++++++
 tb/tb_prg_tile_sched.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prg_tile_sched.sv
// Tiled primary-ray sample scheduler: walks the frame tile by tile, emitting SPP
// (x, y, s) slots per pixel, gated by downstream credits, with a drain/done phase.
module prg_tile_sched #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int TILE_W  = 8,
  parameter int TILE_H  = 8,
  parameter int SPP     = 1,
  parameter int CREDITS = 16,
  parameter int XW      = $clog2(H_RES),
  parameter int YW      = $clog2(V_RES),
  parameter int SW      = (SPP > 1) ? $clog2(SPP) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          en,
  input  logic          credit_ret,
  output logic          out_valid,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic [SW-1:0] out_s,
  output logic          out_first,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic          credit_err
);

  localparam int CW  = $clog2(CREDITS + 1);
  localparam int NTX = H_RES / TILE_W;
  localparam int NTY = V_RES / TILE_H;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_reg;
  logic [XW-1:0] tx_reg, px_reg;
  logic [YW-1:0] ty_reg, py_reg;
  logic [SW-1:0] s_reg;
  logic [CW-1:0] credit_reg, credit_next;

  logic issue, ret_sat;
  logic s_max, px_max, py_max, tx_max, ty_max, all_zero, all_max;

  always_comb begin
    s_max    = (s_reg  == SW'(SPP - 1));
    px_max   = (px_reg == XW'(TILE_W - 1));
    py_max   = (py_reg == YW'(TILE_H - 1));
    tx_max   = (tx_reg == XW'(NTX - 1));
    ty_max   = (ty_reg == YW'(NTY - 1));
    all_max  = s_max && px_max && py_max && tx_max && ty_max;
    all_zero = (s_reg == '0) && (px_reg == '0) && (py_reg == '0) &&
               (tx_reg == '0) && (ty_reg == '0);
  end

  // Credit bookkeeping runs in every state so late returns during DRAIN count.
  always_comb begin
    issue       = (state_reg == RUN) && en && (credit_reg != '0);
    ret_sat     = credit_ret && !issue && (credit_reg == CW'(CREDITS));
    credit_next = credit_reg;
    if (issue && !credit_ret)
      credit_next = credit_reg - 1'b1;
    else if (credit_ret && !issue && !ret_sat)
      credit_next = credit_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      tx_reg     <= '0;
      ty_reg     <= '0;
      px_reg     <= '0;
      py_reg     <= '0;
      s_reg      <= '0;
      credit_reg <= CW'(CREDITS);
      out_valid  <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_s      <= '0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      credit_err <= 1'b0;
    end else begin
      credit_reg <= credit_next;
      if (ret_sat)
        credit_err <= 1'b1;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      case (state_reg)
        IDLE: begin
          // A start coinciding with the done pulse belongs to the old frame.
          if (start && !done) begin
            state_reg <= RUN;
            busy      <= 1'b1;
            tx_reg    <= '0;
            ty_reg    <= '0;
            px_reg    <= '0;
            py_reg    <= '0;
            s_reg     <= '0;
          end
        end
        RUN: begin
          if (issue) begin
            out_valid <= 1'b1;
            out_x     <= XW'(int'(tx_reg) * TILE_W + int'(px_reg));
            out_y     <= YW'(V_RES - 1 - (int'(ty_reg) * TILE_H + int'(py_reg)));
            out_s     <= s_reg;
            out_first <= all_zero;
            out_last  <= all_max;
            if (all_max)
              state_reg <= DRAIN;
            if (!s_max) s_reg <= s_reg + 1'b1;
            else begin
              s_reg <= '0;
              if (!px_max) px_reg <= px_reg + 1'b1;
              else begin
                px_reg <= '0;
                if (!py_max) py_reg <= py_reg + 1'b1;
                else begin
                  py_reg <= '0;
                  if (!tx_max) tx_reg <= tx_reg + 1'b1;
                  else begin
                    tx_reg <= '0;
                    if (!ty_max) ty_reg <= ty_reg + 1'b1;
                    else         ty_reg <= '0;
                  end
                end
              end
            end
          end
        end
        DRAIN: begin
          if (credit_next == CW'(CREDITS)) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prg_tile_sched.sv
// Directed bench for prg_tile_sched on a 4x4 frame, 2x2 tiles, SPP=2, 3 credits.
module tb_prg_tile_sched;

  localparam int H = 4, V = 4, TW = 2, TH = 2, NS = 2, CR = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1, start = 1'b0, en = 1'b0, credit_ret = 1'b0;
  logic       out_valid, out_first, out_last, busy, done, credit_err;
  logic [1:0] out_x, out_y;
  logic [0:0] out_s;

  always #5 clk = ~clk;

  prg_tile_sched #(
    .H_RES(H), .V_RES(V), .TILE_W(TW), .TILE_H(TH), .SPP(NS), .CREDITS(CR)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .en(en), .credit_ret(credit_ret),
    .out_valid(out_valid), .out_x(out_x), .out_y(out_y), .out_s(out_s),
    .out_first(out_first), .out_last(out_last), .busy(busy), .done(done),
    .credit_err(credit_err)
  );

  int checks = 0, errors = 0;
  int n_got = 0, done_cnt = 0;
  logic [1:0] gx[64], gy[64];
  logic       gs[64], gf[64], gl[64];
  logic       loop_en = 1'b0;
  logic [1:0] pipe = 2'b00;

  // Expected walk: s, px, py, tx, ty innermost first; y counted top-down.
  function automatic logic [1:0] ex(int k);
    return 2'(((k / 8) % 2) * 2 + (k / 2) % 2);
  endfunction
  function automatic logic [1:0] ey(int k);
    return 2'(3 - (((k / 16) % 2) * 2 + (k / 4) % 2));
  endfunction
  function automatic logic es(int k);
    return 1'(k % 2);
  endfunction

  task automatic tick();
    @(negedge clk);
    if (out_valid && n_got < 64) begin
      gx[n_got] = out_x; gy[n_got] = out_y; gs[n_got] = out_s[0];
      gf[n_got] = out_first; gl[n_got] = out_last;
      n_got++;
    end
    if (done) done_cnt++;
    pipe = {pipe[0], out_valid & loop_en};
    if (loop_en) credit_ret = pipe[1];
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; en = 1'b0; credit_ret = 1'b0;
    loop_en = 1'b0; pipe = 2'b00;
    tick(); tick();
    rst = 1'b0;
    n_got = 0; done_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      gx[i] = 'x; gy[i] = 'x; gs[i] = 'x; gf[i] = 'x; gl[i] = 'x;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || credit_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: valid=%b busy=%b done=%b err=%b, want all 0",
               out_valid, busy, done, credit_err);
    end
    checks++;
    if (out_x !== 2'd0 || out_y !== 2'd0 || out_s !== 1'b0 || out_first !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs: x=%0d y=%0d s=%0d f=%b l=%b, want all 0",
               out_x, out_y, out_s, out_first, out_last);
    end
    checks++;
    if (dut.credit_reg !== 2'd3) begin
      errors++;
      $display("FAIL reset_credits: got %0d want 3", dut.credit_reg);
    end
    $display("reset: done");
  endtask

  task automatic test_full_frame();
    do_reset();
    loop_en = 1'b1; en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 300 && done_cnt == 0; i++) tick();
    repeat (4) tick();
    checks++;
    if (n_got !== 32) begin
      errors++; $display("FAIL full_count: got %0d issues want 32", n_got);
    end
    for (int k = 0; k < 32 && k < n_got; k++) begin
      checks++;
      if (gx[k] !== ex(k) || gy[k] !== ey(k) || gs[k] !== es(k) ||
          gf[k] !== (k == 0) || gl[k] !== (k == 31)) begin
        errors++;
        $display("FAIL full_seq[%0d]: got (%0d,%0d,%0d) f%b l%b want (%0d,%0d,%0d) f%b l%b",
                 k, gx[k], gy[k], gs[k], gf[k], gl[k], ex(k), ey(k), es(k), k == 0, k == 31);
      end
    end
    checks++;
    if (gx[4] !== 2'd0 || gy[4] !== 2'd2 || gs[4] !== 1'b0) begin
      errors++; $display("FAIL full_5th: got (%0d,%0d,%0d) want (0,2,0)", gx[4], gy[4], gs[4]);
    end
    checks++;
    if (gx[8] !== 2'd2 || gy[8] !== 2'd3 || gs[8] !== 1'b0) begin
      errors++; $display("FAIL full_9th: got (%0d,%0d,%0d) want (2,3,0)", gx[8], gy[8], gs[8]);
    end
    checks++;
    if (gx[31] !== 2'd3 || gy[31] !== 2'd0 || gs[31] !== 1'b1 || gl[31] !== 1'b1) begin
      errors++;
      $display("FAIL full_32nd: got (%0d,%0d,%0d) l%b want (3,0,1) l1", gx[31], gy[31], gs[31], gl[31]);
    end
    checks++;
    if (done_cnt !== 1 || busy !== 1'b0 || credit_err !== 1'b0) begin
      errors++;
      $display("FAIL full_end: done_cnt=%0d busy=%b err=%b want 1,0,0", done_cnt, busy, credit_err);
    end
    $display("full_frame: %0d issues, %0d done pulses", n_got, done_cnt);
  endtask

  task automatic test_credit_exhaust();
    do_reset();
    en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    checks++;
    if (n_got !== 3 || busy !== 1'b1) begin
      errors++; $display("FAIL exhaust_stall: issues=%0d busy=%b want 3,1", n_got, busy);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (gx[k] !== ex(k) || gy[k] !== ey(k) || gs[k] !== es(k)) begin
        errors++;
        $display("FAIL exhaust_seq[%0d]: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                 k, gx[k], gy[k], gs[k], ex(k), ey(k), es(k));
      end
    end
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    repeat (10) tick();
    checks++;
    if (n_got !== 4 || gx[3] !== 2'd1 || gy[3] !== 2'd3 || gs[3] !== 1'b1) begin
      errors++;
      $display("FAIL exhaust_one_more: issues=%0d last=(%0d,%0d,%0d) want 4,(1,3,1)",
               n_got, gx[3], gy[3], gs[3]);
    end
    $display("credit_exhaust: %0d issues", n_got);
  endtask

  task automatic test_en_toggle();
    logic [3:0] pat;
    int bad;
    logic e;
    pat = 4'b1001;
    bad = 0;
    do_reset();
    loop_en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 400 && done_cnt == 0; i++) begin
      en = pat[i % 4];
      e = en;
      tick();
      if (out_valid && !e) bad++;
    end
    en = 1'b1;
    repeat (4) tick();
    checks++;
    if (bad !== 0 || n_got !== 32 || done_cnt !== 1) begin
      errors++;
      $display("FAIL en_toggle: issues_while_off=%0d issues=%0d done=%0d want 0,32,1",
               bad, n_got, done_cnt);
    end
    for (int k = 0; k < 32 && k < n_got; k++) begin
      checks++;
      if (gx[k] !== ex(k) || gy[k] !== ey(k) || gs[k] !== es(k)) begin
        errors++;
        $display("FAIL en_seq[%0d]: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                 k, gx[k], gy[k], gs[k], ex(k), ey(k), es(k));
      end
    end
    $display("en_toggle: %0d issues", n_got);
  endtask

  task automatic test_simul_ret();
    do_reset();
    en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && n_got < 2; i++) tick();
    en = 1'b0;
    tick();
    checks++;
    if (n_got !== 2 || dut.credit_reg !== 2'd1) begin
      errors++; $display("FAIL simul_setup: issues=%0d credits=%0d want 2,1", n_got, dut.credit_reg);
    end
    en = 1'b1; credit_ret = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || dut.credit_reg !== 2'd1) begin
        errors++;
        $display("FAIL simul_cycle%0d: valid=%b credits=%0d want 1,1", i, out_valid, dut.credit_reg);
      end
    end
    en = 1'b0;
    tick(); tick();
    checks++;
    if (dut.credit_reg !== 2'd3 || credit_err !== 1'b0) begin
      errors++; $display("FAIL simul_refill: credits=%0d err=%b want 3,0", dut.credit_reg, credit_err);
    end
    tick();
    credit_ret = 1'b0;
    repeat (3) tick();
    checks++;
    if (credit_err !== 1'b1 || dut.credit_reg !== 2'd3) begin
      errors++; $display("FAIL simul_overflow: err=%b credits=%0d want 1,3", credit_err, dut.credit_reg);
    end
    for (int k = 2; k < 6; k++) begin
      checks++;
      if (gx[k] !== ex(k) || gy[k] !== ey(k) || gs[k] !== es(k)) begin
        errors++;
        $display("FAIL simul_seq[%0d]: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                 k, gx[k], gy[k], gs[k], ex(k), ey(k), es(k));
      end
    end
    do_reset();
    checks++;
    if (credit_err !== 1'b0) begin
      errors++; $display("FAIL simul_err_clear: err=%b want 0", credit_err);
    end
    $display("simul_ret: credit_err latched and cleared");
  endtask

  task automatic test_reset_mid();
    do_reset();
    loop_en = 1'b1; en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40 && n_got < 5; i++) tick();
    rst = 1'b1; loop_en = 1'b0; pipe = 2'b00; credit_ret = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || dut.credit_reg !== 2'd3) begin
      errors++;
      $display("FAIL midrst_state: valid=%b busy=%b done=%b credits=%0d want 0,0,0,3",
               out_valid, busy, done, dut.credit_reg);
    end
    rst = 1'b0;
    repeat (5) tick();
    checks++;
    if (done_cnt !== 0 || n_got !== 5) begin
      errors++; $display("FAIL midrst_quiet: done=%0d issues=%0d want 0,5", done_cnt, n_got);
    end
    n_got = 0;
    loop_en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && n_got < 1; i++) tick();
    checks++;
    if (gx[0] !== 2'd0 || gy[0] !== 2'd3 || gs[0] !== 1'b0 || gf[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_restart: got (%0d,%0d,%0d) f%b want (0,3,0) f1", gx[0], gy[0], gs[0], gf[0]);
    end
    $display("reset_mid: restart at (%0d,%0d,%0d)", gx[0], gy[0], gs[0]);
  endtask

  task automatic test_start_ignored();
    do_reset();
    en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 200 && n_got < 32; i++) begin
      credit_ret = (n_got >= 2);
      start = (n_got == 10 || n_got == 20);
      tick();
    end
    credit_ret = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    checks++;
    if (done_cnt !== 0 || busy !== 1'b1 || dut.credit_reg !== 2'd1) begin
      errors++;
      $display("FAIL drain_hold0: done=%0d busy=%b credits=%0d want 0,1,1", done_cnt, busy, dut.credit_reg);
    end
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    repeat (3) tick();
    checks++;
    if (done_cnt !== 0 || busy !== 1'b1) begin
      errors++; $display("FAIL drain_hold1: done=%0d busy=%b want 0,1", done_cnt, busy);
    end
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL drain_done: done=%b busy=%b want 1,0", done, busy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    checks++;
    if (done_cnt !== 1 || busy !== 1'b0 || n_got !== 32 || credit_err !== 1'b0) begin
      errors++;
      $display("FAIL start_ign_end: done=%0d busy=%b issues=%0d err=%b want 1,0,32,0",
               done_cnt, busy, n_got, credit_err);
    end
    for (int k = 0; k < 32 && k < n_got; k++) begin
      checks++;
      if (gx[k] !== ex(k) || gy[k] !== ey(k) || gs[k] !== es(k)) begin
        errors++;
        $display("FAIL start_ign_seq[%0d]: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                 k, gx[k], gy[k], gs[k], ex(k), ey(k), es(k));
      end
    end
    $display("start_ignored: %0d issues, %0d done pulses", n_got, done_cnt);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_credit_exhaust();
    test_en_toggle();
    test_simul_ret();
    test_reset_mid();
    test_start_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
